// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO pointer, occupancy, threshold and watermark controller
//
// Pointer/occupancy controller for a single-clock FIFO backed by an external
// dual-port RAM. DEPTH may be any value >= 2 (not only powers of two).
//
// Optional feature macro: FIFO_PTR_CTRL_ERR_EN (sticky overflow/underflow flags).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   write_en, read_en producer/consumer requests
//   flush             synchronous clear of pointers, count and peak
//   af_thresh         almost-full threshold (count >= af_thresh)
//   ae_thresh         almost-empty threshold (count <= ae_thresh)
//   err_clr           clears sticky error flags
//   wr_accept         write taken this cycle
//   rd_accept         read taken this cycle
//   write_ptr         RAM write address
//   read_ptr          RAM read address
//   count             occupancy
//   peak              highest occupancy since reset or flush
//   full, empty, almost_full, almost_empty   status flags
//   overflow, underflow                      sticky error flags

module fifo_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write_en,
    input  logic          read_en,
    input  logic          flush,
    input  logic [CW-1:0] af_thresh,
    input  logic [CW-1:0] ae_thresh,
    input  logic          err_clr,
    output logic          wr_accept,
    output logic          rd_accept,
    output logic [AW-1:0] write_ptr,
    output logic [AW-1:0] read_ptr,
    output logic [CW-1:0] count,
    output logic [CW-1:0] peak,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [CW-1:0] count_nxt;
    logic [AW-1:0] write_ptr_inc;
    logic [AW-1:0] read_ptr_inc;

    // Status flags come straight from the count register.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    // Acceptance uses the current-cycle state, so a full FIFO never takes a
    // write even if a read is accepted in the same cycle.
    assign wr_accept = write_en && !full;
    assign rd_accept = read_en && !empty;

    // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
    assign write_ptr_inc = (write_ptr == LAST_PTR) ? '0 : write_ptr + 1'b1;
    assign read_ptr_inc  = (read_ptr == LAST_PTR) ? '0 : read_ptr + 1'b1;

    always_comb begin
        count_nxt = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            peak      <= '0;
        end else if (flush) begin
            // Accepts in the flush cycle are discarded.
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            peak      <= '0;
        end else begin
            if (wr_accept) begin
                write_ptr <= write_ptr_inc;
            end
            if (rd_accept) begin
                read_ptr <= read_ptr_inc;
            end
            count <= count_nxt;
            if (count_nxt > peak) begin
                peak <= count_nxt;
            end
        end
    end

`ifdef FIFO_PTR_CTRL_ERR_EN
    // Sticky flags; a new error in the clear cycle wins over err_clr.
    // Flush deliberately leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (read_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
